vga_text_scanner: RTL and testbench



---
 rtl/vga_text_scanner.sv | 160 ++++++++++++++++
 tb/tb_vga_text_scanner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_scanner.sv
// vga_text_scanner: VGA 640x480 timing generator and 40x15 text-cell scanner with a blinking block cursor
// Ports:
//   clk, rst_n             clock and synchronous active-low reset (honoured regardless of pix_en)
//   pix_en                 pixel tick; every register, outputs included, advances only when high
//   char_addr, char_data   text RAM address (row*TEXT_COLS+col) and the character code it returns
//   font_addr, font_pixel  font ROM lookup {ascii, pixel row, pixel col} and its replicated pixel byte
//   fg_color, bg_color     glyph and background colours
//   cursor_en/col/row      block cursor enable and text-cell position
//   rgb, hsync, vsync, de  VGA outputs, all three ticks behind the scan counters
module vga_text_scanner #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int TEXT_COLS    = 40,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    output logic [9:0]  char_addr,
    input  logic [7:0]  char_data,
    output logic [16:0] font_addr,
    input  logic [7:0]  font_pixel,
    input  logic [7:0]  fg_color,
    input  logic [7:0]  bg_color,
    input  logic        cursor_en,
    input  logic [5:0]  cursor_col,
    input  logic [3:0]  cursor_row,
    output logic [7:0]  rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        de
);
    localparam int              H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int              V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int              BW         = $clog2(BLINK_FRAMES + 1);
    localparam logic [9:0]      H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]      V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]      H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0]      V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0]      HS_BEG     = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]      HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]      VS_BEG     = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]      VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]      COLS       = 10'(TEXT_COLS);
    localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [9:0]    h_cnt, v_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          h_last, v_last, active, hs_pulse, vs_pulse, cur_hit, pix_on;
    logic [5:0]    text_col;
    logic [3:0]    text_row;

    // Sync flags travel the pipeline active-high so that the all-zero reset
    // state keeps hsync/vsync deasserted while the pipeline refills.
    logic [4:0]    s1_row, s2_row;
    logic [3:0]    s1_col, s2_col;
    logic          s1_active, s1_hs_pulse, s1_vs_pulse, s1_cur;
    logic          s2_active, s2_hs_pulse, s2_vs_pulse, s2_cur;
    logic [7:0]    s2_char;

    always_comb begin
        h_last   = h_cnt == H_LAST;
        v_last   = v_cnt == V_LAST;
        active   = h_cnt < H_VIS && v_cnt < V_VIS;
        hs_pulse = h_cnt >= HS_BEG && h_cnt < HS_END;
        vs_pulse = v_cnt >= VS_BEG && v_cnt < VS_END;
        text_col = h_cnt[9:4];
        text_row = v_cnt[8:5];
        cur_hit  = cursor_en && blink_phase && text_col == cursor_col &&
                   text_row == cursor_row && v_cnt[4:0] >= 5'd28;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (pix_en) begin
            h_cnt <= h_last ? '0 : h_cnt + 10'd1;
            if (h_last)
                v_cnt <= v_last ? '0 : v_cnt + 10'd1;
            if (h_last && v_last) begin
                blink_cnt <= blink_cnt == BLINK_LAST ? '0 : blink_cnt + BW'(1);
                if (blink_cnt == BLINK_LAST)
                    blink_phase <= ~blink_phase;
            end
        end
    end

    // Stage 1: text RAM address plus the per-pixel context that rides along.
    // The address only moves in the active area so the RAM output stays stable in blanking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            char_addr   <= '0;
            s1_row      <= '0;
            s1_col      <= '0;
            s1_active   <= 1'b0;
            s1_hs_pulse <= 1'b0;
            s1_vs_pulse <= 1'b0;
            s1_cur      <= 1'b0;
        end else if (pix_en) begin
            if (active)
                char_addr <= 10'(text_row) * COLS + 10'(text_col);
            s1_row      <= v_cnt[4:0];
            s1_col      <= h_cnt[3:0];
            s1_active   <= active;
            s1_hs_pulse <= hs_pulse;
            s1_vs_pulse <= vs_pulse;
            s1_cur      <= cur_hit;
        end
    end

    // Stage 2: character code arrives one tick after its address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_char     <= '0;
            s2_row      <= '0;
            s2_col      <= '0;
            s2_active   <= 1'b0;
            s2_hs_pulse <= 1'b0;
            s2_vs_pulse <= 1'b0;
            s2_cur      <= 1'b0;
        end else if (pix_en) begin
            s2_char     <= char_data;
            s2_row      <= s1_row;
            s2_col      <= s1_col;
            s2_active   <= s1_active;
            s2_hs_pulse <= s1_hs_pulse;
            s2_vs_pulse <= s1_vs_pulse;
            s2_cur      <= s1_cur;
        end
    end

    assign font_addr = {s2_char, s2_row, s2_col};
    // The ROM replicates the pixel across the byte; any set bit means glyph-on.
    assign pix_on    = |font_pixel;

    // Stage 3: registered outputs, syncs kept aligned with the colour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb   <= '0;
            de    <= 1'b0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pix_en) begin
            rgb   <= !s2_active ? 8'h00 : ((pix_on ^ s2_cur) ? fg_color : bg_color);
            de    <= s2_active;
            hsync <= ~s2_hs_pulse;
            vsync <= ~s2_vs_pulse;
        end
    end
endmodule

// File: tb/tb_vga_text_scanner.sv
// tb_vga_text_scanner: scoreboard and probe-table bench for vga_text_scanner on a shrunken raster
module tb_vga_text_scanner;
    localparam int HA = 96, HF = 4, HS = 8, HB = 4;
    localparam int VA = 96, VF = 2, VS = 2, VB = 2;
    localparam int BF = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int NFR = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic [9:0]  char_addr;
    logic [7:0]  char_data = 8'h00;
    logic [16:0] font_addr;
    logic [7:0]  font_pixel;
    logic [7:0]  fg_color = 8'hFF;
    logic [7:0]  bg_color = 8'h03;
    logic        cursor_en = 1'b1;
    logic [5:0]  cursor_col = 6'd5;
    logic [3:0]  cursor_row = 4'd2;
    logic [7:0]  rgb;
    logic        hsync, vsync, de;

    vga_text_scanner #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .TEXT_COLS(40), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .char_addr(char_addr), .char_data(char_data),
        .font_addr(font_addr), .font_pixel(font_pixel),
        .fg_color(fg_color), .bg_color(bg_color),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_rd(input logic [9:0] a);
        return (a == 10'd85) ? 8'h61 : (a[7:0] ^ 8'hA5);
    endfunction

    function automatic logic font_on(input logic [7:0] a, input int r, input int c);
        return a < 8'h80 && ((int'(a) + r * 3 + c) % 5) < 2;
    endfunction

    // Text RAM answers within half a clock and holds while the address holds.
    always @(negedge clk) char_data <= ram_rd(char_addr);
    assign font_pixel = font_on(font_addr[16:9], int'(font_addr[8:4]), int'(font_addr[3:0])) ? 8'hFF : 8'h00;

    typedef struct {
        logic [7:0] rgb;
        logic [7:0] rgb_nc;
        logic       de, hs, vs;
        int         frame;
        int         n;
    } exp_t;

    typedef struct {
        int          h, v;
        logic [9:0]  addr;
        logic        chk_font;
        logic [16:0] font;
    } probe_t;

    exp_t   sb[$];
    probe_t probes[7];
    int     vs_falls[$];
    int     checks = 0, passes = 0;
    int     n = 0, pend_font = -1;
    int     hs_low = 0, vs_low = 0, de_hi = 0, de_rise = 0, hs_falls = 0, hs_bad = 0, hs_last = -1;
    int     inv[NFR];
    logic   prev_hs = 1'b1, prev_vs = 1'b1, prev_de = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic exp_t model(input int t);
        exp_t e;
        int h, v, f;
        logic act, on, cur;
        logic [7:0] a;
        h   = t % HT;
        v   = (t / HT) % VT;
        f   = t / FR;
        act = h < HA && v < VA;
        a   = ram_rd(10'((v / 32) * 40 + h / 16));
        on  = font_on(a, v % 32, h % 16);
        cur = cursor_en && h / 16 == int'(cursor_col) && v / 32 == int'(cursor_row) &&
              v % 32 >= 28 && (f / BF) % 2 == 1;
        e.de     = act;
        e.hs     = !(h >= HA + HF && h < HA + HF + HS);
        e.vs     = !(v >= VA + VF && v < VA + VF + VS);
        e.rgb    = !act ? 8'h00 : ((on ^ cur) ? fg_color : bg_color);
        e.rgb_nc = !act ? 8'h00 : (on ? fg_color : bg_color);
        e.frame  = f;
        e.n      = t;
        return e;
    endfunction

    task automatic step();
        exp_t e, o;
        int hit;
        e   = model(n);
        hit = -1;
        if (n < FR)
            foreach (probes[i])
                if (probes[i].h == n % HT && probes[i].v == n / HT) hit = i;
        sb.push_back(e);
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        if (n < 2) check($sformatf("release latency tick %0d de/rgb", n), 64'({de, rgb}), 64'd0);
        if (pend_font >= 0)
            check($sformatf("font_addr probe %0d", pend_font), 64'(font_addr), 64'(probes[pend_font].font));
        pend_font = -1;
        if (hit >= 0) begin
            check($sformatf("char_addr probe %0d", hit), 64'(char_addr), 64'(probes[hit].addr));
            if (probes[hit].chk_font) pend_font = hit;
        end
        if (sb.size() == 3) begin
            o = sb.pop_front();
            check($sformatf("pixel n=%0d rgb/de/hs/vs", o.n), 64'({rgb, de, hsync, vsync}),
                  64'({o.rgb, o.de, o.hs, o.vs}));
            if (o.frame < NFR && rgb !== o.rgb_nc) inv[o.frame]++;
            if (prev_vs && !vsync) vs_falls.push_back(o.n);
            if (o.frame == 1) begin
                hs_low += int'(!hsync);
                vs_low += int'(!vsync);
                de_hi  += int'(de);
                if (!prev_de && de) de_rise++;
                if (prev_hs && !hsync) begin
                    if (hs_last >= 0 && o.n - hs_last != HT) hs_bad++;
                    hs_last = o.n;
                    hs_falls++;
                end
            end
            prev_hs = hsync;
            prev_vs = vsync;
            prev_de = de;
        end
        n++;
    endtask

    task automatic stall();
        logic [63:0] snap;
        snap   = 64'({rgb, de, hsync, vsync, char_addr, font_addr});
        pix_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall hold clk %0d", i), 64'({rgb, de, hsync, vsync, char_addr, font_addr}), snap);
        end
    endtask

    initial begin
        #2_000_000;
        checks++;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $display("%0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

    initial begin
        probes[0] = '{83, 71, 10'd85, 1'b1, 17'h0C273};
        probes[1] = '{95, 95, 10'd85, 1'b1, 17'h0C3FF};
        probes[2] = '{0, 0, 10'd0, 1'b1, 17'h14A00};
        probes[3] = '{17, 33, 10'd41, 1'b1, 17'h11811};
        probes[4] = '{95, 5, 10'd5, 1'b1, 17'h1405F};
        probes[5] = '{100, 5, 10'd5, 1'b0, 17'h0};
        probes[6] = '{50, 97, 10'd85, 1'b0, 17'h0};
        for (int i = 0; i < NFR; i++) inv[i] = 0;

        pix_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (150) @(posedge clk);
        #1;
        check("pre-reset de", 64'(de), 64'd1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset hsync/vsync", 64'({hsync, vsync}), 64'd3);
        check("reset de/rgb", 64'({de, rgb}), 64'd0);
        check("reset char_addr", 64'(char_addr), 64'd0);
        check("reset font_addr", 64'(font_addr), 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < NFR * FR + 2; k++) begin
            if (n == 10 * HT + 50) stall();
            step();
        end

        check("hsync low ticks per frame", 64'(hs_low), 64'(HS * VT));
        check("hsync falls per frame", 64'(hs_falls), 64'(VT));
        check("hsync period errors", 64'(hs_bad), 64'd0);
        check("vsync low ticks per frame", 64'(vs_low), 64'(VS * HT));
        check("de high ticks per frame", 64'(de_hi), 64'(HA * VA));
        check("de lines per frame", 64'(de_rise), 64'(VA));
        check("vsync falls seen", 64'(vs_falls.size()), 64'(NFR));
        if (vs_falls.size() >= 2)
            check("vsync period", 64'(vs_falls[1] - vs_falls[0]), 64'(FR));
        check("cursor pixels frame 0", 64'(inv[0]), 64'd0);
        check("cursor pixels frame 1", 64'(inv[1]), 64'd0);
        check("cursor pixels frame 2", 64'(inv[2]), 64'd64);
        check("cursor pixels frame 3", 64'(inv[3]), 64'd64);
        check("cursor pixels frame 4", 64'(inv[4]), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
